// File: rtl/mult_div_32.sv
// rtl/mult_div_32.sv - iterative 32-bit multiply/divide unit with HI/LO result registers
//
// Sequential MULTU/MULT/DIVU/DIV unit. A started operation always takes
// 33 clock edges: capture (E0), 32 iteration edges (E1..E32) and a fix-up
// edge (E33) that writes hi/lo and pulses done.
//
// Ports:
//   clk          - clock, all state changes on its rising edge
//   reset        - asynchronous active-high reset
//   start        - request a new operation, sampled only while busy=0
//   op           - 00 MULTU, 01 MULT, 10 DIVU, 11 DIV
//   input1       - multiplicand / dividend
//   input2       - multiplier / divisor
//   busy         - operation in progress
//   done         - one-cycle pulse, hi/lo hold the new result
//   hi, lo       - product[63:32]/[31:0] or remainder/quotient
//   div_by_zero  - raised with done when the divisor was zero
//
// Configuration macro: MULT_DIV_32_SIGNED_EN
//   defined   - op[0] selects signed MULT/DIV, sign fix-up applied at E33
//   undefined - op[0] ignored, all operations unsigned, same latency

`timescale 1ns/1ps

module mult_div_32 #(
    parameter int WIDTH = 32
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             start,
    input  logic [1:0]       op,
    input  logic [WIDTH-1:0] input1,
    input  logic [WIDTH-1:0] input2,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] hi,
    output logic [WIDTH-1:0] lo,
    output logic             div_by_zero
);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_RUN  = 2'd1,
        S_FIX  = 2'd2
    } state_t;

    state_t             state_q;
    state_t             state_d;
    logic [4:0]         cnt;
    logic               is_div;
    logic               dbz_q;
    logic [WIDTH-1:0]   opnd;       // multiplicand or divisor magnitude
    logic [WIDTH-1:0]   acc_hi;     // partial product high / partial remainder
    logic [WIDTH-1:0]   acc_lo;     // multiplier bits / dividend-then-quotient bits

    logic [WIDTH-1:0]   mag1;
    logic [WIDTH-1:0]   mag2;
    logic [WIDTH:0]     mul_sum;
    logic [WIDTH:0]     div_sh;
    logic               div_fits;
    logic [WIDTH-1:0]   div_diff;
    logic [WIDTH-1:0]   res_hi;
    logic [WIDTH-1:0]   res_lo;

`ifdef MULT_DIV_32_SIGNED_EN
    logic               neg_res;    // product / quotient must be negated
    logic               neg_rem;    // remainder takes the dividend's sign
    logic [2*WIDTH-1:0] prod_neg;

    always_comb begin
        mag1 = (op[0] && input1[WIDTH-1]) ? (~input1 + 1'b1) : input1;
        mag2 = (op[0] && input2[WIDTH-1]) ? (~input2 + 1'b1) : input2;
    end
`else
    logic               unused_sign_sel;

    assign unused_sign_sel = op[0];

    always_comb begin
        mag1 = input1;
        mag2 = input2;
    end
`endif

    // One shift-add step: add the multiplicand when the multiplier LSB is
    // set, then shift the 65-bit {carry, acc_hi, acc_lo} right by one.
    assign mul_sum  = {1'b0, acc_hi} + (acc_lo[0] ? {1'b0, opnd} : '0);

    // One restoring step: shift the next dividend bit into the remainder
    // and subtract the divisor only if it fits. The remainder is always
    // below the divisor, so the W-bit modular difference is exact.
    assign div_sh   = {acc_hi, acc_lo[WIDTH-1]};
    assign div_fits = (div_sh >= {1'b0, opnd});
    assign div_diff = div_sh[WIDTH-1:0] - opnd;

    always_comb begin
        res_hi = acc_hi;
        res_lo = acc_lo;
`ifdef MULT_DIV_32_SIGNED_EN
        prod_neg = ~{acc_hi, acc_lo} + 1'b1;
        if (is_div) begin
            if (neg_res) res_lo = ~acc_lo + 1'b1;
            if (neg_rem) res_hi = ~acc_hi + 1'b1;
        end else if (neg_res) begin
            {res_hi, res_lo} = prod_neg;
        end
`endif
        // Divide by zero: quotient all ones; the remainder path already
        // reproduces the dividend since every trial subtraction "fits".
        if (is_div && dbz_q) res_lo = '1;
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) state_q <= S_IDLE;
        else       state_q <= state_d;
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            S_IDLE:  if (start) state_d = S_RUN;
            S_RUN:   if (cnt == 5'd31) state_d = S_FIX;
            S_FIX:   state_d = S_IDLE;
            default: state_d = S_IDLE;
        endcase
    end

    assign busy = (state_q != S_IDLE);

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            cnt         <= '0;
            is_div      <= 1'b0;
            dbz_q       <= 1'b0;
            opnd        <= '0;
            acc_hi      <= '0;
            acc_lo      <= '0;
            hi          <= '0;
            lo          <= '0;
            done        <= 1'b0;
            div_by_zero <= 1'b0;
`ifdef MULT_DIV_32_SIGNED_EN
            neg_res     <= 1'b0;
            neg_rem     <= 1'b0;
`endif
        end else begin
            done        <= 1'b0;
            div_by_zero <= 1'b0;
            case (state_q)
                S_IDLE: begin
                    if (start) begin
                        is_div <= op[1];
                        dbz_q  <= op[1] && (input2 == '0);
                        opnd   <= mag2;
                        acc_hi <= '0;
                        acc_lo <= mag1;
                        cnt    <= '0;
`ifdef MULT_DIV_32_SIGNED_EN
                        neg_res <= op[0] && (input1[WIDTH-1] ^ input2[WIDTH-1]);
                        neg_rem <= op[0] && input1[WIDTH-1];
`endif
                    end
                end
                S_RUN: begin
                    cnt <= cnt + 5'd1;
                    if (is_div) begin
                        acc_hi <= div_fits ? div_diff : div_sh[WIDTH-1:0];
                        acc_lo <= {acc_lo[WIDTH-2:0], div_fits};
                    end else begin
                        acc_hi <= mul_sum[WIDTH:1];
                        acc_lo <= {mul_sum[0], acc_lo[WIDTH-1:1]};
                    end
                end
                S_FIX: begin
                    hi          <= res_hi;
                    lo          <= res_lo;
                    done        <= 1'b1;
                    div_by_zero <= is_div && dbz_q;
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_mult_div_32.sv
// tb/tb_mult_div_32.sv - self-checking bench for mult_div_32 (vector table, corner sequences, random vs model)

`timescale 1ns/1ps

module tb_mult_div_32;

`ifdef MULT_DIV_32_SIGNED_EN
    localparam bit SIGNED_EN = 1'b1;
`else
    localparam bit SIGNED_EN = 1'b0;
`endif

    logic        clk = 1'b0;
    logic        reset;
    logic        start;
    logic [1:0]  op;
    logic [31:0] input1;
    logic [31:0] input2;
    logic        busy;
    logic        done;
    logic [31:0] hi;
    logic [31:0] lo;
    logic        div_by_zero;

    int checks = 0;
    int errors = 0;

    logic [31:0] exp_hi, exp_lo, prev_hi, prev_lo;
    logic        exp_dbz;

    typedef struct {
        logic [1:0]  op;
        logic [31:0] a;
        logic [31:0] b;
        logic [31:0] eh;
        logic [31:0] el;
        logic        ed;
    } vec_t;

    vec_t vecs[11];

    mult_div_32 #(.WIDTH(32)) dut (
        .clk        (clk),
        .reset      (reset),
        .start      (start),
        .op         (op),
        .input1     (input1),
        .input2     (input2),
        .busy       (busy),
        .done       (done),
        .hi         (hi),
        .lo         (lo),
        .div_by_zero(div_by_zero)
    );

    always #5 clk = ~clk;

    initial begin
        #1000000;
        $display("FAIL watchdog: simulation did not finish, got timeout required finish");
        $fatal(1, "watchdog");
    end

    task automatic check(input string name, input logic [31:0] got, input logic [31:0] want);
        checks++;
        if (got !== want) begin
            errors++;
            $display("FAIL %s: got %h required %h", name, got, want);
        end
    endtask

    // Reference: plain arithmetic on the operands as integers.
    function automatic void model(input logic [1:0] mop, input logic [31:0] a, input logic [31:0] b,
                                  output logic [31:0] eh, output logic [31:0] el, output logic ed);
        longint sa, sb, p;
        logic [63:0] up;
        bit sg;
        sg = SIGNED_EN && mop[0];
        sa = $signed(a);
        sb = $signed(b);
        ed = 1'b0;
        if (!mop[1]) begin
            if (sg) begin
                p = sa * sb;
                {eh, el} = p;
            end else begin
                up = {32'b0, a} * {32'b0, b};
                {eh, el} = up;
            end
        end else if (b == 32'd0) begin
            el = 32'hFFFF_FFFF;
            eh = a;
            ed = 1'b1;
        end else if (sg) begin
            el = 32'(sa / sb);
            eh = 32'(sa % sb);
        end else begin
            el = a / b;
            eh = a % b;
        end
    endfunction

    // Called away from a clock edge; returns #1 after the capture edge E0.
    task automatic start_op(input logic [1:0] o, input logic [31:0] a, input logic [31:0] b);
        start   = 1'b1;
        op      = o;
        input1  = a;
        input2  = b;
        prev_hi = hi;
        prev_lo = lo;
        @(posedge clk);
        #1;
        start  = 1'b0;
        op     = 2'($urandom);
        input1 = $urandom;
        input2 = $urandom;
    endtask

    task automatic wait_done(input string tag, input int already, input bit chk_after);
        int n;
        bit seen;
        bit hold_bad;
        n = already;
        seen = 1'b0;
        hold_bad = 1'b0;
        while (!seen && n < 40) begin
            @(posedge clk);
            #1;
            n++;
            if (done) seen = 1'b1;
            else if (hi !== prev_hi || lo !== prev_lo || div_by_zero !== 1'b0 || busy !== 1'b1)
                hold_bad = 1'b1;
        end
        check({tag, " latency"}, 32'(n), 32'd33);
        check({tag, " hold"}, {31'b0, hold_bad}, 32'd0);
        check({tag, " hi"}, hi, exp_hi);
        check({tag, " lo"}, lo, exp_lo);
        check({tag, " dbz"}, {31'b0, div_by_zero}, {31'b0, exp_dbz});
        check({tag, " busy_at_done"}, {31'b0, busy}, 32'd0);
        if (chk_after) begin
            @(posedge clk);
            #1;
            check({tag, " done_after"}, {31'b0, done}, 32'd0);
            check({tag, " dbz_after"}, {31'b0, div_by_zero}, 32'd0);
            check({tag, " hi_kept"}, hi, exp_hi);
        end
    endtask

    initial begin
        int pulses;
        logic [1:0]  ro;
        logic [31:0] ra, rb;

        vecs[0]  = '{2'b00, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFFE, 32'h0000_0001, 1'b0};
        vecs[4]  = '{2'b10, 32'h0000_0064, 32'h0000_0000, 32'h0000_0064, 32'hFFFF_FFFF, 1'b1};
        vecs[5]  = '{2'b10, 32'd100,       32'd7,         32'd2,         32'd14,        1'b0};
        vecs[6]  = '{2'b00, 32'h0001_0000, 32'h0001_0000, 32'h0000_0001, 32'h0000_0000, 1'b0};
        vecs[7]  = '{2'b11, 32'hFFFF_FFF9, 32'h0000_0000, 32'hFFFF_FFF9, 32'hFFFF_FFFF, 1'b1};
        vecs[9]  = '{2'b01, 32'h8000_0000, 32'h8000_0000, 32'h4000_0000, 32'h0000_0000, 1'b0};
        vecs[10] = '{2'b00, 32'h0000_0000, 32'h1234_5678, 32'h0000_0000, 32'h0000_0000, 1'b0};
`ifdef MULT_DIV_32_SIGNED_EN
        vecs[1]  = '{2'b01, 32'hFFFF_FFFD, 32'h0000_0007, 32'hFFFF_FFFF, 32'hFFFF_FFEB, 1'b0};
        vecs[2]  = '{2'b11, 32'hFFFF_FFF9, 32'h0000_0002, 32'hFFFF_FFFF, 32'hFFFF_FFFD, 1'b0};
        vecs[3]  = '{2'b11, 32'h8000_0000, 32'hFFFF_FFFF, 32'h0000_0000, 32'h8000_0000, 1'b0};
        vecs[8]  = '{2'b11, 32'h0000_0007, 32'hFFFF_FFFE, 32'h0000_0001, 32'hFFFF_FFFD, 1'b0};
`else
        vecs[1]  = '{2'b01, 32'hFFFF_FFFD, 32'h0000_0007, 32'h0000_0006, 32'hFFFF_FFEB, 1'b0};
        vecs[2]  = '{2'b11, 32'hFFFF_FFF9, 32'h0000_0002, 32'h0000_0001, 32'h7FFF_FFFC, 1'b0};
        vecs[3]  = '{2'b11, 32'h8000_0000, 32'hFFFF_FFFF, 32'h8000_0000, 32'h0000_0000, 1'b0};
        vecs[8]  = '{2'b11, 32'h0000_0007, 32'hFFFF_FFFE, 32'h0000_0007, 32'h0000_0000, 1'b0};
`endif

        reset  = 1'b1;
        start  = 1'b0;
        op     = 2'b00;
        input1 = 32'd0;
        input2 = 32'd0;
        repeat (2) @(posedge clk);
        #1;
        check("reset busy", {31'b0, busy}, 32'd0);
        check("reset done", {31'b0, done}, 32'd0);
        check("reset dbz", {31'b0, div_by_zero}, 32'd0);
        check("reset hi", hi, 32'd0);
        check("reset lo", lo, 32'd0);
        @(negedge clk);
        reset = 1'b0;

        for (int i = 0; i < 11; i++) begin
            @(negedge clk);
            exp_hi  = vecs[i].eh;
            exp_lo  = vecs[i].el;
            exp_dbz = vecs[i].ed;
            start_op(vecs[i].op, vecs[i].a, vecs[i].b);
            wait_done($sformatf("vec%0d", i), 0, 1'b1);
        end

        // start in the done cycle is a new E0
        @(negedge clk);
        exp_hi = 32'd2; exp_lo = 32'd14; exp_dbz = 1'b0;
        start_op(2'b10, 32'd100, 32'd7);
        wait_done("b2b_first", 0, 1'b0);
        exp_hi = 32'd0; exp_lo = 32'd6; exp_dbz = 1'b0;
        start_op(2'b00, 32'd2, 32'd3);
        wait_done("b2b_second", 0, 1'b1);

        // start with new operands at E5 while busy is ignored
        @(negedge clk);
        exp_hi = 32'd0; exp_lo = 32'd77; exp_dbz = 1'b0;
        start_op(2'b00, 32'd11, 32'd7);
        repeat (4) begin
            @(posedge clk);
            #1;
        end
        start  = 1'b1;
        op     = 2'b10;
        input1 = 32'd1000;
        input2 = 32'd0;
        @(posedge clk);
        #1;
        start = 1'b0;
        wait_done("busy_start", 5, 1'b1);

        // reset at E10 of an operation aborts it without a done pulse
        @(negedge clk);
        start_op(2'b00, 32'd5, 32'd5);
        repeat (9) begin
            @(posedge clk);
            #1;
        end
        @(posedge clk);
        reset = 1'b1;
        #1;
        check("abort busy", {31'b0, busy}, 32'd0);
        check("abort done", {31'b0, done}, 32'd0);
        check("abort hi", hi, 32'd0);
        check("abort lo", lo, 32'd0);
        @(negedge clk);
        reset = 1'b0;
        pulses = 0;
        repeat (40) begin
            @(posedge clk);
            #1;
            if (done) pulses++;
        end
        check("abort no_done", 32'(pulses), 32'd0);
        @(negedge clk);
        exp_hi = 32'd0; exp_lo = 32'd42; exp_dbz = 1'b0;
        start_op(2'b00, 32'd6, 32'd7);
        wait_done("after_reset", 0, 1'b1);

        // random operations against the arithmetic model
        for (int i = 0; i < 40; i++) begin
            @(negedge clk);
            ro = 2'($urandom);
            ra = $urandom;
            case ($urandom_range(0, 3))
                0:       rb = 32'd0;
                1:       rb = 32'($urandom_range(1, 16));
                2:       rb = -32'($urandom_range(1, 16));
                default: rb = $urandom;
            endcase
            model(ro, ra, rb, exp_hi, exp_lo, exp_dbz);
            start_op(ro, ra, rb);
            wait_done($sformatf("rand%0d op%0d %h %h", i, ro, ra, rb), 0, 1'b0);
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/mult_div_32.md
MULT_DIV_32 -- requirements
Module: mult_div_32

Interface
REQ-001 SHALL have parameter WIDTH, default 32: operand width; only 32 is supported.
REQ-002 SHALL have port clk, input, 1 bit: the single clock; all state changes on its rising edge.
REQ-003 SHALL have port reset, input, 1 bit: asynchronous, active-high reset.
REQ-004 SHALL have port start, input, 1 bit: request a new operation; sampled only when busy=0.
REQ-005 SHALL have port op, input, 2 bits: 00 MULTU, 01 MULT, 10 DIVU, 11 DIV.
REQ-006 SHALL have port input1, input, 32 bits: multiplicand or dividend, from the register-file read port A.
REQ-007 SHALL have port input2, input, 32 bits: multiplier or divisor, from the register-file read port B.
REQ-008 SHALL have port busy, output, 1 bit: an operation is in progress.
REQ-009 SHALL have port done, output, 1 bit: one-cycle pulse meaning hi/lo now hold the new result.
REQ-010 SHALL have port hi, output, 32 bits: HI register (product[63:32] or remainder).
REQ-011 SHALL have port lo, output, 32 bits: LO register (product[31:0] or quotient).
REQ-012 SHALL have port div_by_zero, output, 1 bit: set alongside done when the divisor was 0.

Function
REQ-013 SHALL implement the FSM IDLE -> RUN -> FIX -> IDLE.
REQ-014 Capture: at edge E0 with start=1 in IDLE, SHALL latch op and operand magnitudes (sign-stripped for signed ops), clear the iteration counter, and set busy=1.
REQ-015 RUN SHALL perform one iteration per edge on E1..E32: shift-add for multiply, restoring shift-subtract for divide; 5-bit counter, leaves RUN when the count reaches 31.
REQ-016 At E33 (FIX), the block SHALL apply sign correction, write hi/lo, set done=1, clear busy, and return to IDLE.
REQ-017 done SHALL be high for exactly the one cycle after E33; latency from start edge to done is fixed at 33 edges for all ops and operand values.
REQ-018 hi/lo SHALL hold their previous values from E0 until E33, and SHALL hold the new result until the next FIX or reset.
REQ-019 start while busy=1 SHALL be ignored, with no effect on operands or state.
REQ-020 start=1 in the done cycle SHALL be accepted as a new E0 (back-to-back operation).
REQ-021 MULT/MULTU SHALL produce the full 64-bit product {hi,lo}, two's-complement for MULT.
REQ-022 DIV/DIVU SHALL set lo=quotient truncated toward zero and hi=remainder, where the remainder takes the sign of the dividend.
REQ-023 Divide by zero SHALL still take the full latency and yield lo=0xFFFFFFFF, hi=input1, with div_by_zero=1 during the done cycle only.
REQ-024 DIV of 0x80000000 by 0xFFFFFFFF SHALL yield lo=0x80000000, hi=0 with no flag raised.
REQ-025 op and input changes after E0 SHALL have no effect on the running operation.

Reset
REQ-026 reset=1 SHALL asynchronously force IDLE, counter=0, busy=0, done=0, div_by_zero=0, hi=0, and lo=0.
REQ-027 Reset during RUN or FIX SHALL abort the operation with no done pulse; the first start after reset deasserts SHALL behave normally.

Configuration
REQ-028 With macro MULT_DIV_32_SIGNED_EN defined, op[0] SHALL select signed MULT/DIV with sign fix-up in FIX.
REQ-029 Without MULT_DIV_32_SIGNED_EN, op[0] SHALL be ignored, every operation SHALL be unsigned, the sign logic SHALL be absent, and latency SHALL be unchanged (FIX still occupies E33).

Verification
REQ-030 MULTU 0xFFFFFFFF x 0xFFFFFFFF -> hi=0xFFFFFFFE, lo=0x00000001; done exactly 33 edges after start.
REQ-031 MULT 0xFFFFFFFD (-3) x 0x00000007 -> hi=0xFFFFFFFF, lo=0xFFFFFFEB.
REQ-032 DIV 0xFFFFFFF9 (-7) / 0x00000002 -> lo=0xFFFFFFFD, hi=0xFFFFFFFF; then DIV 0x80000000 / 0xFFFFFFFF -> lo=0x80000000, hi=0.
REQ-033 DIVU 0x00000064 / 0 -> lo=0xFFFFFFFF, hi=0x00000064, div_by_zero=1 for one cycle only.
REQ-034 start with new operands at E5 during busy -> ignored, result from original operands; reset pulse at E10 of a second operation -> busy=0, hi=lo=0, no done pulse.
REQ-035 start asserted in the done cycle (MULTU 2 x 3 after a DIVU) -> accepted; hi=0, lo=6 at the next done, 33 edges later.
